instr_fetch_unit: RTL and testbench

- Upstream stage of the control unit in the single-cycle MIPS core.
- Holds the program counter (PC) and fetches instructions over a ready-based handshake to instruction memory.
- Presents the latched instruction and its Op_code/Funct fields to the control unit.
- Computes the next PC from the jump, Branch and ALU Zero signals it receives back.

---
 rtl/instr_fetch_unit.sv | 94 +++++++++
 tb/tb_instr_fetch_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// PC holder and instruction fetcher feeding the MIPS control unit.
// Optional retired-instruction counter enabled by `define FETCH_PERF_CNT_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] Imem_addr,
    output logic        Imem_req,
    input  logic [31:0] Imem_rdata,
    input  logic        Imem_ready,
    input  logic        jump,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        stall,
    output logic [31:0] Instr,
    output logic [5:0]  Op_code,
    output logic [5:0]  Funct,
    output logic        Instr_valid,
    output logic [31:0] PC,
    output logic [31:0] PC_plus4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] Retired_cnt
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] EXEC  = 2'd2;

    logic [1:0]  state;
    logic [31:0] next_pc;
    logic [31:0] jump_tgt;
    logic [31:0] br_off;
    logic        exec_exit;

    assign Imem_addr   = PC;
    assign Imem_req    = (state == FETCH);
    assign Instr_valid = (state == EXEC);
    assign Op_code     = Instr[31:26];
    assign Funct       = Instr[5:0];
    assign PC_plus4    = PC + 32'd4;
    assign exec_exit   = (state == EXEC) && !stall;

    // word offset sign-extended, then scaled by 4
    assign br_off   = {{14{Instr[15]}}, Instr[15:0], 2'b00};
    assign jump_tgt = {PC_plus4[31:28], Instr[25:0], 2'b00};

    always_comb begin
        next_pc = PC_plus4;
        if (jump) begin
            next_pc = jump_tgt;
        end else if (Branch && Zero) begin
            next_pc = PC_plus4 + br_off;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            PC    <= RESET_PC;
            Instr <= '0;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (Imem_ready) begin
                        Instr <= Imem_rdata;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (!stall) begin
                        PC    <= next_pc;
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Retired_cnt <= '0;
        end else if (exec_exit) begin
            Retired_cnt <= Retired_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: fetch queue scoreboard plus
// a negedge monitor checking handshakes and the presented instruction.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Imem_addr;
    logic        Imem_req;
    logic [31:0] Imem_rdata;
    logic        Imem_ready;
    logic        jump;
    logic        Branch;
    logic        Zero;
    logic        stall;
    logic [31:0] Instr;
    logic [5:0]  Op_code;
    logic [5:0]  Funct;
    logic        Instr_valid;
    logic [31:0] PC;
    logic [31:0] PC_plus4;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] Retired_cnt;
    logic [31:0] exp_ret = 32'd0;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] cur_instr = 32'd0;
    logic [31:0] cur_pc    = 32'd0;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .Imem_addr   (Imem_addr),
        .Imem_req    (Imem_req),
        .Imem_rdata  (Imem_rdata),
        .Imem_ready  (Imem_ready),
        .jump        (jump),
        .Branch      (Branch),
        .Zero        (Zero),
        .stall       (stall),
        .Instr       (Instr),
        .Op_code     (Op_code),
        .Funct       (Funct),
        .Instr_valid (Instr_valid),
        .PC          (PC),
        .PC_plus4    (PC_plus4)
`ifdef FETCH_PERF_CNT_EN
        ,
        .Retired_cnt (Retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // monitor: scoreboard pop on handshake, content check while valid
    always @(negedge clk) begin
        if (!rst && Imem_req) begin
            if (exp_addr_q.size() == 0) begin
                if (Imem_ready) chk("unexpected_fetch", Imem_addr, 32'hxxxx_xxxx);
            end else if (Imem_ready) begin
                chk("fetch_addr", Imem_addr, exp_addr_q[0]);
                cur_pc    = exp_addr_q.pop_front();
                cur_instr = exp_data_q.pop_front();
            end else begin
                chk("wait_addr_stable", Imem_addr, exp_addr_q[0]);
            end
        end
        if (!rst && Instr_valid) begin
            chk("instr", Instr, cur_instr);
            chk("op_code", {26'd0, Op_code}, {26'd0, cur_instr[31:26]});
            chk("funct", {26'd0, Funct}, {26'd0, cur_instr[5:0]});
            chk("pc", PC, cur_pc);
            chk("pc_plus4", PC_plus4, cur_pc + 32'd4);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!Imem_req && n < 20) begin
            tick();
            n++;
        end
        chk("req_timeout", {31'd0, Imem_req}, 32'd1);
    endtask

    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data,
                            input int waits);
        exp_addr_q.push_back(addr);
        exp_data_q.push_back(data);
        wait_req();
        repeat (waits) begin
            Imem_ready = 1'b0;
            jump = 1'b1; Branch = 1'b1; Zero = 1'b1; stall = 1'b1;
            Imem_rdata = 32'hBAD0_BAD0;
            tick();
            chk("wait_req_held", {31'd0, Imem_req}, 32'd1);
            chk("wait_no_valid", {31'd0, Instr_valid}, 32'd0);
        end
        jump = 1'b0; Branch = 1'b0; Zero = 1'b0; stall = 1'b0;
        Imem_ready = 1'b1;
        Imem_rdata = data;
        tick();
        chk("valid_after_ready", {31'd0, Instr_valid}, 32'd1);
        Imem_ready = 1'b0;
        Imem_rdata = 32'hDEAD_BEEF;
    endtask

    task automatic do_exec(input logic j, input logic b, input logic z,
                           input int stalls, input logic [31:0] exp_next);
        jump = j; Branch = b; Zero = z;
        Imem_ready = 1'b1;
        Imem_rdata = 32'hDEAD_BEEF;
        repeat (stalls) begin
            stall = 1'b1;
            tick();
            chk("stall_valid_held", {31'd0, Instr_valid}, 32'd1);
        end
        stall = 1'b0;
        tick();
        chk("exit_valid_low", {31'd0, Instr_valid}, 32'd0);
        chk("next_pc", Imem_addr, exp_next);
`ifdef FETCH_PERF_CNT_EN
        exp_ret = exp_ret + 32'd1;
        chk("retired_cnt", Retired_cnt, exp_ret);
`endif
        jump = 1'b0; Branch = 1'b0; Zero = 1'b0;
        Imem_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        Imem_rdata = 32'h0; Imem_ready = 1'b0;
        jump = 1'b0; Branch = 1'b0; Zero = 1'b0; stall = 1'b0;
        tick();
        tick();
        chk("rst_pc", PC, 32'h0);
        chk("rst_instr", Instr, 32'h0);
        chk("rst_valid", {31'd0, Instr_valid}, 32'd0);
        chk("rst_req", {31'd0, Imem_req}, 32'd0);
        chk("rst_opfunct", {20'd0, Op_code, Funct}, 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_req", {31'd0, Imem_req}, 32'd0);

        do_fetch(32'h0, 32'h0000_0020, 0);
        do_exec(1'b0, 1'b0, 1'b0, 0, 32'h4);
        do_fetch(32'h4, 32'h0000_0020, 0);
        do_exec(1'b0, 1'b0, 1'b0, 0, 32'h8);
        do_fetch(32'h8, 32'h0800_0010, 0);
        do_exec(1'b1, 1'b0, 1'b0, 0, 32'h40);
        do_fetch(32'h40, 32'h0800_0040, 3);
        do_exec(1'b1, 1'b0, 1'b0, 0, 32'h100);
        do_fetch(32'h100, 32'h1000_FFFF, 0);
        do_exec(1'b0, 1'b1, 1'b1, 2, 32'h100);
        do_fetch(32'h100, 32'h1000_FFFF, 0);
        do_exec(1'b0, 1'b1, 1'b0, 0, 32'h104);
        do_fetch(32'h104, 32'h1000_0003, 0);
        do_exec(1'b1, 1'b1, 1'b1, 0, 32'hC);
        do_fetch(32'hC, 32'h1000_0002, 0);
        do_exec(1'b0, 1'b1, 1'b1, 0, 32'h18);
        do_fetch(32'h18, 32'h1000_FFF8, 0);
        do_exec(1'b0, 1'b1, 1'b1, 0, 32'hFFFF_FFFC);
        do_fetch(32'hFFFF_FFFC, 32'h0800_0010, 1);
        do_exec(1'b1, 1'b0, 1'b0, 0, 32'h40);

        wait_req();
        chk("rst_test_addr", Imem_addr, 32'h40);
        tick();
        tick();
        #2;
        rst = 1'b1;
        Imem_ready = 1'b1;
        Imem_rdata = 32'h1234_5678;
        #1;
        chk("async_rst_pc", PC, 32'h0);
        chk("async_rst_valid", {31'd0, Instr_valid}, 32'd0);
        chk("async_rst_req", {31'd0, Imem_req}, 32'd0);
        tick();
        chk("rst_discard_instr", Instr, 32'h0);
        rst = 1'b0;
        Imem_ready = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        exp_ret = 32'd0;
        chk("rst_retired", Retired_cnt, 32'd0);
`endif
        #1;
        chk("post_rst_idle", {31'd0, Imem_req}, 32'd0);
        do_fetch(32'h0, 32'h0000_0020, 0);
        do_exec(1'b0, 1'b0, 1'b0, 0, 32'h4);

        tick();
        chk("queue_drained", exp_addr_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
